set_scan: RTL and testbench
===========================

SET_SCAN -- requirements
Module: set_scan

Interface
REQ-001 SHALL have parameter GRID, default 8, meaning grid side length; points (x,y) scanned are x,y = 1..GRID, with GRID <= 2^CW-1.
REQ-002 SHALL have parameter CW, default 4, meaning coordinate/radius field width.
REQ-003 SHALL have parameter CNT_W, default 8, meaning candidate width, >= clog2(GRID*GRID+1).
REQ-004 SHALL have port clk  in  1  sole clock, all logic on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port en  in  1  start request, sampled only while busy=0.
REQ-007 SHALL have port central  in  6*CW  circle centres {Ax,Ay,Bx,By,Cx,Cy}, Ax in the MSBs.
REQ-008 SHALL have port radius  in  3*CW  circle radii {rA,rB,rC}, rA in the MSBs.
REQ-009 SHALL have port mode  in  2  count selector, sampled together with en.
REQ-010 SHALL have port busy  out  1  scan in progress.
REQ-011 SHALL have port valid  out  1  one-cycle result strobe.
REQ-012 SHALL have port candidate  out  CNT_W  point count result.

Function
REQ-013 SHALL implement FSM IDLE -> SCAN -> DONE -> IDLE.
REQ-014 In IDLE, when en=1, SHALL latch central, radius and mode, clear all counters, reset the scan pointer to (1,1), and enter SCAN with busy=1 on the next cycle.
REQ-015 In SCAN, SHALL evaluate exactly one grid point per cycle, x-major then y, for GRID*GRID cycles, then enter DONE.
REQ-016 Point P SHALL be a member of circle K iff (Px-Kx)^2+(Py-Ky)^2 <= rK^2, evaluated at full precision: differences as signed CW+1 bits, sum as 2*CW+3 bits, with no truncation.
REQ-017 SHALL count per point with accumulators nA, nAB (A and B), nX (A xor B) and n2 (exactly two of A, B, C).
REQ-018 Result by latched mode SHALL be: 00 gives nA; 01 gives nAB; 10 gives nX; 11 as specified under Configuration.
REQ-019 In DONE, SHALL drive valid=1 and busy=0 for exactly one cycle with candidate equal to the result, then return to IDLE.
REQ-020 candidate SHALL hold its value until the next DONE; valid SHALL be 0 in all other cycles.
REQ-021 Latency SHALL be: en sampled at edge 0 gives busy=1 after edges 1..GRID*GRID and valid=1 after edge GRID*GRID+1 (65 for GRID=8).
REQ-022 SHALL ignore en while busy=1, and SHALL ignore changes to central, radius and mode after latching.
REQ-023 SHALL accept en=1 in the DONE cycle as a new start (busy=0), so that back-to-back operations are possible.
REQ-024 A centre outside 1..GRID (including 0) SHALL be legal and SHALL count only the in-grid points; radius 0 SHALL count the centre point only if it lies on the grid.

Reset
REQ-025 When rst=1 at a clock edge, SHALL go to IDLE with busy=0, valid=0, candidate=0 and all counters 0.
REQ-026 rst SHALL take priority over en.
REQ-027 rst during SCAN SHALL abort the scan, with no valid pulse for the aborted operation.

Configuration
REQ-028 With macro SET_SCAN_TRIPLE_EN defined, SHALL evaluate circle C, and mode 11 SHALL give n2.
REQ-029 Without SET_SCAN_TRIPLE_EN, SHALL not synthesise C-membership or n2 logic, SHALL ignore the C fields, and mode 11 SHALL complete normally with candidate=0.
REQ-030 Modes 00/01/10 SHALL be identical with or without the macro.

Verification
REQ-031 Scenario 1: A=(4,4), rA=2, mode 00 -> candidate=13, valid one cycle, 65 cycles after en.
REQ-032 Scenario 2: A=(3,3), rA=1, B=(4,3), rB=1 -> mode 01 gives candidate=2, mode 10 gives candidate=6, run back-to-back with en held in the DONE cycle.
REQ-033 Scenario 3: A=(4,4), rA=15, mode 00 -> candidate=64; A=(0,0), rA=0 -> candidate=0; A=(4,4), rA=0 -> candidate=1.
REQ-034 Scenario 4: A=(3,3), B=(4,3), C=(3,4), all r=1, mode 11 -> candidate=3 with SET_SCAN_TRIPLE_EN defined, candidate=0 without it.
REQ-035 Scenario 5: start with A=(4,4), rA=2 and mode 00, then during SCAN pulse en with different central/mode -> ignored, candidate=13.
REQ-036 Scenario 6: rst at cycle 20 of SCAN -> busy=0, valid=0, candidate=0, no valid pulse; a following en with A=(4,4), rA=2 -> candidate=13.

Source files
------------

// File: rtl/set_scan.sv
// Grid scanner: counts points of a GRIDxGRID lattice lying inside circles A and B
// (and C when built with SET_SCAN_TRIPLE_EN), one point per clock cycle.
module set_scan #(
    parameter int GRID  = 8,
    parameter int CW    = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [6*CW-1:0]     central,
    input  logic [3*CW-1:0]     radius,
    input  logic [1:0]          mode,
    output logic                busy,
    output logic                valid,
    output logic [CNT_W-1:0]    candidate
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

`ifdef SET_SCAN_TRIPLE_EN
    localparam int NC = 3;
`else
    localparam int NC = 2;
`endif

    localparam logic [CW-1:0] LAST = CW'(GRID);
    localparam int DW = 2*CW + 3;

    logic [1:0]            state_reg;
    logic [2*CW*NC-1:0]    central_reg;
    logic [CW*NC-1:0]      radius_reg;
    logic [1:0]            mode_reg;
    logic [CW-1:0]         px_reg, py_reg;
    logic [CNT_W-1:0]      na_reg, nab_reg, nx_reg;
    logic [CNT_W-1:0]      na_next, nab_next, nx_next;
    logic [CNT_W-1:0]      candidate_reg, result_next;
    logic                  valid_reg;
    logic [NC-1:0]         member;

    // Circle gi = 0 is A (most significant field), 1 is B, 2 is C.
    genvar gi;
    generate
        for (gi = 0; gi < NC; gi++) begin : g_circle
            logic [CW-1:0]        kx, ky, kr;
            logic signed [CW:0]   ddx, ddy;
            logic signed [DW-1:0] sx, sy;
            logic [DW-1:0]        d2, r2;

            assign kx  = central_reg[2*CW*(NC-gi)-1 -: CW];
            assign ky  = central_reg[2*CW*(NC-gi)-CW-1 -: CW];
            assign kr  = radius_reg[CW*(NC-gi)-1 -: CW];
            assign ddx = $signed({1'b0, px_reg}) - $signed({1'b0, kx});
            assign ddy = $signed({1'b0, py_reg}) - $signed({1'b0, ky});
            assign sx  = DW'(ddx);
            assign sy  = DW'(ddy);
            assign d2  = $unsigned(sx * sx) + $unsigned(sy * sy);
            assign r2  = DW'(kr) * DW'(kr);
            assign member[gi] = (d2 <= r2);
        end
    endgenerate

    assign na_next  = na_reg  + CNT_W'(member[0]);
    assign nab_next = nab_reg + CNT_W'(member[0] & member[1]);
    assign nx_next  = nx_reg  + CNT_W'(member[0] ^ member[1]);

`ifdef SET_SCAN_TRIPLE_EN
    logic [CNT_W-1:0] n2_reg, n2_next;
    logic             two_hit;

    assign two_hit = (member[0] & member[1] & ~member[2]) |
                     (member[0] & ~member[1] & member[2]) |
                     (~member[0] & member[1] & member[2]);
    assign n2_next = n2_reg + CNT_W'(two_hit);

    always_ff @(posedge clk) begin
        if (rst || (state_reg != SCAN && en))
            n2_reg <= '0;
        else if (state_reg == SCAN)
            n2_reg <= n2_next;
    end
`else
    logic [CNT_W-1:0] n2_next;
    logic             unused_c;

    assign n2_next  = '0;
    assign unused_c = ^{central[2*CW-1:0], radius[CW-1:0]};
`endif

    // The result is taken from the next-values so the final point is included.
    always_comb begin
        result_next = na_next;
        case (mode_reg)
            2'b00:   result_next = na_next;
            2'b01:   result_next = nab_next;
            2'b10:   result_next = nx_next;
            default: result_next = n2_next;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            central_reg   <= '0;
            radius_reg    <= '0;
            mode_reg      <= 2'b00;
            px_reg        <= '0;
            py_reg        <= '0;
            na_reg        <= '0;
            nab_reg       <= '0;
            nx_reg        <= '0;
            candidate_reg <= '0;
            valid_reg     <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (en) begin
                        central_reg <= central[6*CW-1 -: 2*CW*NC];
                        radius_reg  <= radius[3*CW-1 -: CW*NC];
                        mode_reg    <= mode;
                        px_reg      <= CW'(1);
                        py_reg      <= CW'(1);
                        na_reg      <= '0;
                        nab_reg     <= '0;
                        nx_reg      <= '0;
                        state_reg   <= SCAN;
                    end else begin
                        state_reg   <= IDLE;
                    end
                end
                SCAN: begin
                    na_reg  <= na_next;
                    nab_reg <= nab_next;
                    nx_reg  <= nx_next;
                    if (py_reg == LAST) begin
                        py_reg <= CW'(1);
                        px_reg <= px_reg + CW'(1);
                    end else begin
                        py_reg <= py_reg + CW'(1);
                    end
                    if (px_reg == LAST && py_reg == LAST) begin
                        state_reg     <= DONE;
                        valid_reg     <= 1'b1;
                        candidate_reg <= result_next;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = (state_reg == SCAN);
    assign valid     = valid_reg;
    assign candidate = candidate_reg;

endmodule

// File: tb/tb_set_scan.sv
// Directed bench for set_scan: hand-computed point counts, latency, back-to-back,
// ignored starts during a scan and reset abort.
module tb_set_scan;

    localparam int CW    = 4;
    localparam int CNT_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b0;
    logic [6*CW-1:0]   central = '0;
    logic [3*CW-1:0]   radius  = '0;
    logic [1:0]        mode    = 2'b00;
    logic              busy, valid;
    logic [CNT_W-1:0]  candidate;

    int tests = 0;
    int fails = 0;

    set_scan #(.GRID(8), .CW(CW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
        .mode(mode), .busy(busy), .valid(valid), .candidate(candidate)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [6*CW-1:0] cen(input int ax, ay, bx, by, cx, cy);
        return {CW'(ax), CW'(ay), CW'(bx), CW'(by), CW'(cx), CW'(cy)};
    endfunction

    function automatic logic [3*CW-1:0] rad(input int ra, rb, rc);
        return {CW'(ra), CW'(rb), CW'(rc)};
    endfunction

    // Drive a start for one edge and confirm the scan begins.
    task automatic start(input string tag, input logic [6*CW-1:0] c,
                         input logic [3*CW-1:0] r, input logic [1:0] m);
        en = 1'b1; central = c; radius = r; mode = m;
        tick();
        en = 1'b0;
        check({tag, "_busy_start"}, int'(busy), 1);
    endtask

    // Wait (bounded) for valid; check latency, result, busy and strobe width.
    task automatic wait_result(input string tag, input int exp_cand, input int exp_lat);
        int cyc = 0;
        while (!valid && cyc < 200) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_cand"}, int'(candidate), exp_cand);
        check({tag, "_busy_done"}, int'(busy), 0);
        $display("[TB] %s: candidate=%0d latency=%0d", tag, candidate, cyc);
    endtask

    task automatic after_pulse(input string tag, input int exp_cand);
        tick();
        check({tag, "_valid_drop"}, int'(valid), 0);
        check({tag, "_cand_hold"}, int'(candidate), exp_cand);
    endtask

    initial begin
        int pulses;

        repeat (3) tick();
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_cand", int'(candidate), 0);
        rst = 1'b0;
        tick();

        // Disk of radius 2 fully inside the grid: 13 points.
        start("s1", cen(4, 4, 0, 0, 0, 0), rad(2, 0, 0), 2'b00);
        wait_result("s1", 13, 64);
        after_pulse("s1", 13);
        repeat (3) tick();
        check("s1_idle_valid", int'(valid), 0);

        // Two overlapping unit plus-shapes: AND = 2, XOR = 6, back-to-back.
        start("s2_and", cen(3, 3, 4, 3, 0, 0), rad(1, 1, 0), 2'b01);
        wait_result("s2_and", 2, 64);
        start("s2_xor", cen(3, 3, 4, 3, 0, 0), rad(1, 1, 0), 2'b10);
        wait_result("s2_xor", 6, 64);
        after_pulse("s2_xor", 6);

        // Boundaries: huge radius, off-grid zero-radius centre, on-grid zero radius.
        start("s3_full", cen(4, 4, 1, 1, 1, 1), rad(15, 3, 3), 2'b00);
        wait_result("s3_full", 64, 64);
        start("s3_zero", cen(0, 0, 4, 4, 4, 4), rad(0, 5, 5), 2'b00);
        wait_result("s3_zero", 0, 64);
        start("s3_point", cen(4, 4, 0, 0, 0, 0), rad(0, 0, 0), 2'b00);
        wait_result("s3_point", 1, 64);

        // Centre on the grid corner: quarter of a radius-2 disk, 6 points.
        start("s3_corner", cen(1, 1, 8, 8, 0, 0), rad(2, 2, 0), 2'b00);
        wait_result("s3_corner", 6, 64);

        // Exactly two of three circles.
        start("s4_two", cen(3, 3, 4, 3, 3, 4), rad(1, 1, 1), 2'b11);
`ifdef SET_SCAN_TRIPLE_EN
        wait_result("s4_two", 3, 64);
`else
        wait_result("s4_two", 0, 64);
`endif

        // Start request while busy must be ignored.
        start("s5", cen(4, 4, 0, 0, 0, 0), rad(2, 0, 0), 2'b00);
        repeat (10) tick();
        en = 1'b1; central = cen(1, 1, 1, 1, 1, 1); radius = rad(15, 15, 15); mode = 2'b10;
        tick();
        en = 1'b0;
        check("s5_busy_mid", int'(busy), 1);
        wait_result("s5", 13, 53);

        // Reset mid-scan aborts with no result pulse.
        start("s6", cen(4, 4, 0, 0, 0, 0), rad(3, 0, 0), 2'b00);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s6_rst_busy", int'(busy), 0);
        check("s6_rst_valid", int'(valid), 0);
        check("s6_rst_cand", int'(candidate), 0);
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (valid) pulses++;
        end
        check("s6_no_pulse", pulses, 0);
        start("s6_restart", cen(4, 4, 0, 0, 0, 0), rad(2, 0, 0), 2'b00);
        wait_result("s6_restart", 13, 64);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
